ex_pipe_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the execute stage; successor to the

---
 rtl/ex_pipe_adder.sv | 175 +++++++++++++++++
 tb/tb_ex_pipe_adder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : ex_pipe_adder
// Purpose  : Pipelined add/subtract unit for the execute stage. The carry
//            chain is split into STAGES slices of WIDTH/STAGES bits. Each
//            slice adds one chunk and registers the chunk carry for the next
//            slice. One operation per cycle over valid/ready handshakes.
//            Reports carry-out and signed overflow.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   operation offered this cycle
//            in_ready   unit accepts an operation this cycle
//            add_in1    operand A
//            add_in2    operand B
//            sub        0: A+B, 1: A-B (A + ~B + 1)
//            sat        (EX_ADD_SAT_EN only) clamp the result on overflow
//            out_valid  add_out/carry_out/overflow valid
//            out_ready  consumer takes the result this cycle
//            add_out    result, modulo 2^WIDTH (or clamped)
//            carry_out  carry from the MSB (for sub: 1 = no borrow)
//            overflow   signed two's-complement overflow
// Config   : `define EX_ADD_SAT_EN adds the sat input and saturation in the
//            last stage
// Revision : 1.0  initial release
// ============================================================================
module ex_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  input  logic             sub,
`ifdef EX_ADD_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int             c_CHUNK = WIDTH / STAGES;
  localparam int             c_LAST  = STAGES - 1;
  localparam logic [WIDTH-1:0] c_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage registers. r_a holds finished sum bits below the processed chunk
  // and the untouched operand A bits above it; r_b holds the (possibly
  // inverted) operand B. The last slot is the output register: r_a is
  // add_out and r_cy is carry_out there.
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic             r_cy  [STAGES];
  logic             r_sat [STAGES];
  logic             r_vld [STAGES];
  logic             r_ovf;

  // Per-stage inputs (from the ports for stage 0, else from the previous
  // stage register) and per-stage chunk-add results.
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic             w_src_cy  [STAGES];
  logic             w_src_sat [STAGES];
  logic             w_src_vld [STAGES];
  logic [WIDTH-1:0] w_nxt_a   [STAGES];
  logic             w_nxt_cy  [STAGES];
  logic [c_CHUNK:0] w_sum;

  logic             w_adv;
  logic             w_sat_in;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_unused;

`ifdef EX_ADD_SAT_EN
  assign w_sat_in = sat;
`else
  assign w_sat_in = 1'b0;
`endif

  // The whole pipe moves together; it only freezes when a finished result
  // is waiting and the consumer refuses it.
  assign w_adv    = ~r_vld[c_LAST] | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_src_a[k]   = '0;
      w_src_b[k]   = '0;
      w_src_cy[k]  = 1'b0;
      w_src_sat[k] = 1'b0;
      w_src_vld[k] = 1'b0;
      w_nxt_a[k]   = '0;
      w_nxt_cy[k]  = 1'b0;
    end

    // Subtraction is A + ~B + 1: invert B once at entry, feed the +1 as the
    // stage-0 carry-in.
    w_src_a[0]   = add_in1;
    w_src_b[0]   = sub ? ~add_in2 : add_in2;
    w_src_cy[0]  = sub;
    w_src_sat[0] = w_sat_in;
    w_src_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_cy[k]  = r_cy[k-1];
      w_src_sat[k] = r_sat[k-1];
      w_src_vld[k] = r_vld[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      w_sum = {1'b0, w_src_a[k][k*c_CHUNK +: c_CHUNK]}
            + {1'b0, w_src_b[k][k*c_CHUNK +: c_CHUNK]}
            + {{c_CHUNK{1'b0}}, w_src_cy[k]};
      w_nxt_a[k]                        = w_src_a[k];
      w_nxt_a[k][k*c_CHUNK +: c_CHUNK]  = w_sum[c_CHUNK-1:0];
      w_nxt_cy[k]                       = w_sum[c_CHUNK];
    end
  end

  // The top chunk is only added in the last stage, so the operand MSBs are
  // still intact at its input.
  assign w_a_msb = w_src_a[c_LAST][WIDTH-1];
  assign w_b_msb = w_src_b[c_LAST][WIDTH-1];
  assign w_ovf   = (w_a_msb == w_b_msb) & (w_nxt_a[c_LAST][WIDTH-1] != w_a_msb);

`ifdef EX_ADD_SAT_EN
  // Both operands share the sign on overflow; A's sign picks the rail.
  assign w_out_nxt = (w_src_sat[c_LAST] & w_ovf) ? (w_a_msb ? c_MIN : c_MAX)
                                                  : w_nxt_a[c_LAST];
`else
  assign w_out_nxt = w_nxt_a[c_LAST];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_cy[k]  <= 1'b0;
        r_sat[k] <= 1'b0;
        r_vld[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_b[k]   <= w_src_b[k];
        r_cy[k]  <= w_nxt_cy[k];
        r_sat[k] <= w_src_sat[k];
        r_vld[k] <= w_src_vld[k];
        r_a[k]   <= (k == c_LAST) ? w_out_nxt : w_nxt_a[k];
      end
      r_ovf <= w_ovf;
    end
  end

  assign out_valid = r_vld[c_LAST];
  assign add_out   = r_a[c_LAST];
  assign carry_out = r_cy[c_LAST];
  assign overflow  = r_ovf;

  // Operand/sat copies in the output slot have no consumer.
  assign w_unused = ^{r_b[c_LAST], r_sat[c_LAST], w_src_sat[c_LAST]};

endmodule
`default_nettype wire

// File: tb/tb_ex_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_pipe_adder
// Purpose  : Scoreboard bench for ex_pipe_adder (WIDTH=32). Expected results
//            are queued on accept and compared when results leave the unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              sub       = 1'b0;
  logic              sat       = 1'b0;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  add_in1   = '0;
  logic [WIDTH-1:0]  add_in2   = '0;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  add_out;
  logic              carry_out;
  logic              overflow;

  always #5 clk = ~clk;

  ex_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .sub       (sub),
`ifdef EX_ADD_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .add_out   (add_out),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  typedef struct {
    logic [31:0] res;
    logic        cy;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  bit   free_run = 1'b1;
  bit   rand_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 33-bit add of A and B' = sub ? ~B : B with carry-in sub.
  function automatic logic [33:0] model(logic [31:0] a, logic [31:0] b,
                                        logic s, logic st);
    logic [31:0] bp;
    logic [32:0] t;
    logic [31:0] r;
    logic        ov;
    bp = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bp} + {32'b0, s};
    r  = t[31:0];
    ov = (a[31] == bp[31]) && (r[31] != a[31]);
`ifdef EX_ADD_SAT_EN
    if (st && ov) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (st) r = r;
`endif
    return {ov, t[32], r};
  endfunction

  // Output side: pop and compare on every transfer out.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("add_out", add_out, e.res);
        check("carry_out", carry_out, e.cy);
        check("overflow", overflow, e.ovf);
        if (e.lat && free_run) check("latency", cyc - e.acc, STAGES);
      end
    end
  end

  // Offer one operation; queue its expected result at the accepting edge.
  task automatic send(logic [31:0] a, logic [31:0] b, logic s, logic st,
                      logic [31:0] er, logic ec, logic eo);
    int   w = 0;
    exp_t e;
    add_in1  = a;
    add_in2  = b;
    sub      = s;
    sat      = st;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.res = er;
    e.cy  = ec;
    e.ovf = eo;
    e.acc = cyc;
    e.lat = free_run;
    q.push_back(e);
    n_in++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] a, b;
    logic        s, st;
    logic [33:0] m;
    a  = $urandom;
    b  = $urandom;
    if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7FFF_FFF0 | a[3:0]};
    s  = 1'($urandom_range(0, 1));
    st = 1'($urandom_range(0, 1));
    m  = model(a, b, s, st);
    send(a, b, s, st, m[31:0], m[32], m[33]);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((q.size() != 0 || out_valid) && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("drain_queue_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_add_out", add_out, 0);
    check("rst_carry", carry_out, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single op, then back-to-back
    send(32'd5, 32'd5, 1'b0, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
    wait_drain();
    send(32'd5, 32'd5,   1'b0, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
    send(32'd5, 32'hA,   1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0);
    send(32'd0, 32'hA,   1'b0, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
    wait_drain();

    // Wrap, carry, overflow, borrow
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send(32'd5,         32'hA, 1'b1, 1'b0, 32'hFFFF_FFFB, 1'b0, 1'b0);
    send(32'hA,         32'd5, 1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b0);
    send(32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    wait_drain();

    // Stall: fill the pipe with the consumer blocked
    free_run  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++)
      send(32'h10 * i + 1, 32'h100, 1'b0, 1'b0, 32'h10 * i + 32'h101, 1'b0, 1'b0);
    in_valid = 1'b1;
    add_in1  = 32'hDEAD_BEEF;
    add_in2  = 32'h1234_5678;
    held     = add_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold", add_out, 32'h0000_0101);
      check("stall_stable", add_out, held);
      add_in1 = $urandom;
      add_in2 = $urandom;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h7000, 32'h0FFF, 1'b0, 1'b0, 32'h0000_7FFF, 1'b0, 1'b0);
    wait_drain();
    free_run = 1'b1;

    // Reset with operations in flight
    send(32'h11, 32'h22, 1'b0, 1'b0, 32'h33, 1'b0, 1'b0);
    send(32'h44, 32'h55, 1'b0, 1'b0, 32'h99, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_add_out", add_out, 0);
    check("midrst_carry", carry_out, 0);
    check("midrst_overflow", overflow, 0);
    n_in = n_in - q.size();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h1234, 32'h1, 1'b0, 1'b0, 32'h0000_1235, 1'b0, 1'b0);
    wait_drain();

`ifdef EX_ADD_SAT_EN
    // Saturation
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    send(32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    send(32'hA,         32'd5, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0);
    wait_drain();
`endif

    // Random traffic with random backpressure
    free_run  = 1'b0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    free_run = 1'b1;

    check("in_out_count", n_out, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
